// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM receive path.
// Sample format helpers used by the demodulator.
package pwm_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int DIV_STEPS = 16;

   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

   typedef enum logic [1:0] {
      IDLE,
      MEAS_HIGH,
      MEAS_LOW
   } state_t;

   // Offset-binary duty to two's complement: flip the MSB.
   function automatic logic signed [SAMPLE_W-1:0] duty_to_sample(
      input logic [SAMPLE_W-1:0] duty
   );
      return {~duty[SAMPLE_W-1], duty[SAMPLE_W-2:0]};
   endfunction

endpackage

// File: rtl/pwm_duty_divider.sv
// Sequential restoring divider: quot = floor(num * 2^16 / den), num < den.
// Loads on start, iterates 16 cycles, holds done for one cycle.
module pwm_duty_divider
   import pwm_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [CNT_W-1:0]    num,
   input  logic [CNT_W-1:0]    den,
   output logic                busy,
   output logic                done,
   output logic [SAMPLE_W-1:0] quot
);

   localparam logic [4:0] LAST = 5'(DIV_STEPS);

   logic                busy_r;
   logic [4:0]          step;
   logic [CNT_W:0]      rem;
   logic [CNT_W-1:0]    den_r;
   logic [SAMPLE_W-1:0] q;

   logic [CNT_W:0] shifted;
   logic [CNT_W:0] diff;
   logic           ge;

   // The low 16 dividend bits are zero, so only the remainder is carried.
   always_comb begin
      shifted = rem << 1;
      diff    = shifted - {1'b0, den_r};
      ge      = shifted >= {1'b0, den_r};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
         step   <= '0;
         rem    <= '0;
         den_r  <= '0;
         q      <= '0;
      end else if (start && !busy_r) begin
         busy_r <= 1'b1;
         step   <= '0;
         rem    <= {1'b0, num};
         den_r  <= den;
         q      <= '0;
      end else if (busy_r) begin
         if (step == LAST) begin
            busy_r <= 1'b0;
         end else begin
            rem  <= ge ? diff : shifted;
            q    <= {q[SAMPLE_W-2:0], ge};
            step <= step + 5'd1;
         end
      end
   end

   always_comb begin
      busy = busy_r;
      done = busy_r && (step == LAST);
      quot = q;
   end

endmodule

// File: rtl/pwm_demodulator.sv
// PWM receive path: synchronize, time each carrier cycle, divide to a duty,
// and emit it as a signed sample; stuck inputs give saturated samples.
module pwm_demodulator
   import pwm_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 65535
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pwm_in,
   input  logic                       enable,
   output logic signed [SAMPLE_W-1:0] sample,
   output logic                       sample_valid,
   output logic                       timeout,
   output logic                       overrun
);

   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   logic sync1;
   logic sync2;
   logic prev;
   logic rise;
   logic fall;

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] per_cnt;
   logic             timed_out;
   logic             load;
   logic             snap;
   logic             to_hit;
   logic signed [SAMPLE_W-1:0] to_sat;

   logic                div_busy;
   logic                div_done;
   logic [SAMPLE_W-1:0] div_quot;

   logic                       ovr_r;
   logic                       to_pend;
   logic signed [SAMPLE_W-1:0] to_val;
   logic signed [SAMPLE_W-1:0] held;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   always_comb begin
      rise = sync2 & ~prev;
      fall = ~sync2 & prev;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      timed_out = per_cnt >= TO_LIM;
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (rise) state_nxt = MEAS_HIGH;
            end
            MEAS_HIGH: begin
               if (fall)           state_nxt = MEAS_LOW;
               else if (timed_out) state_nxt = IDLE;
            end
            MEAS_LOW: begin
               if (rise)           state_nxt = MEAS_HIGH;
               else if (timed_out) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      snap   = enable && (state == MEAS_LOW) && rise;
      to_hit = enable && timed_out &&
               (((state == MEAS_HIGH) && !fall) ||
                ((state == MEAS_LOW) && !rise));
      to_sat = (state == MEAS_HIGH) ? SAMPLE_MAX : SAMPLE_MIN;
      load   = (state_nxt == MEAS_HIGH) && (state != MEAS_HIGH);
   end

   // The falling-edge cycle already belongs to the low phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_cnt  <= '0;
         per_cnt <= '0;
      end else if (load) begin
         hi_cnt  <= CNT_W'(1);
         per_cnt <= CNT_W'(1);
      end else if (state == MEAS_HIGH) begin
         per_cnt <= sat_inc(per_cnt);
         if (!fall) hi_cnt <= sat_inc(hi_cnt);
      end else if (state == MEAS_LOW) begin
         per_cnt <= sat_inc(per_cnt);
      end
   end

   pwm_duty_divider #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk   (clk),
      .reset (reset),
      .start (snap),
      .num   (hi_cnt),
      .den   (per_cnt),
      .busy  (div_busy),
      .done  (div_done),
      .quot  (div_quot)
   );

   // A pending timeout waits one cycle if the divider finishes alongside it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovr_r   <= 1'b0;
         to_pend <= 1'b0;
         to_val  <= '0;
      end else begin
         ovr_r <= snap && div_busy;
         if (to_hit) begin
            to_pend <= 1'b1;
            to_val  <= to_sat;
         end else if (to_pend && !div_done) begin
            to_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)             held <= '0;
      else if (sample_valid) held <= sample;
   end

   always_comb begin
      sample_valid = div_done | to_pend;
      timeout      = to_pend & ~div_done;
      overrun      = ovr_r;
      if (div_done)     sample = duty_to_sample(div_quot);
      else if (to_pend) sample = to_val;
      else              sample = held;
   end

endmodule

// File: tb/tb_pwm_demodulator.sv
// Scoreboard bench for pwm_demodulator: PWM periods are driven, expected
// samples queued from pin timing, and a monitor pops them on each strobe.
module tb_pwm_demodulator;
   import pwm_pkg::*;

   localparam int CNT_W = 16;
   localparam int TO    = 400;
   // Pin edge to strobe: two sync edges, the snapshot edge, 16 steps.
   localparam int LAT   = 19;
   localparam int GAP   = 18;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic pwm_in = 1'b0;
   logic enable = 1'b0;
   logic signed [15:0] sample;
   logic sample_valid;
   logic timeout;
   logic overrun;

   pwm_demodulator #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pwm_in       (pwm_in),
      .enable       (enable),
      .sample       (sample),
      .sample_valid (sample_valid),
      .timeout      (timeout),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic signed [15:0] val;
      logic               to;
      int                 due;
   } exp_t;

   exp_t q[$];
   int compared   = 0;
   int mismatched = 0;
   int ovr_seen   = 0;
   int exp_ovr    = 0;
   logic signed [15:0] held = '0;
   bit measuring = 0;
   int rise_c    = 0;
   int fall_c    = 0;
   int last_acc  = -1000;

   function automatic logic signed [15:0] ref_sample(int hi, int per);
      longint d;
      d = (longint'(hi) * 65536) / longint'(per);
      return 16'(d - 32768);
   endfunction

   task automatic check(string name, int act, int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (overrun) ovr_seen++;
      if (sample_valid) begin
         if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_strobe: got sample %0d, expected none (cycle %0d)",
                     sample, cyc);
         end else begin
            e = q.pop_front();
            check("sample", int'(sample), int'(e.val));
            check("timeout_flag", int'(timeout), int'(e.to));
            check("strobe_cycle", cyc, e.due);
         end
         held = sample;
      end else begin
         check("sample_hold", int'(sample), int'(held));
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pin_rise();
      int per;
      int hi;
      tick(1);
      pwm_in = 1'b1;
      if (enable && measuring) begin
         per = cyc - rise_c;
         hi  = fall_c - rise_c;
         if (cyc - last_acc >= GAP) begin
            q.push_back('{ref_sample(hi, per), 1'b0, cyc + LAT});
            last_acc = cyc;
         end else begin
            exp_ovr++;
         end
      end
      if (enable) begin
         measuring = 1;
         rise_c    = cyc;
      end
   endtask

   task automatic pin_fall();
      tick(1);
      pwm_in = 1'b0;
      fall_c = cyc;
   endtask

   task automatic run_period(int h, int p);
      pin_rise();
      tick(h - 1);
      pin_fall();
      tick(p - h - 1);
   endtask

   task automatic finish_seq();
      pin_rise();
      tick(4);
      enable    = 1'b0;
      measuring = 0;
      pwm_in    = 1'b0;
      tick(40);
      enable = 1'b1;
      tick(3);
   endtask

   task automatic expect_to(logic signed [15:0] v);
      q.push_back('{v, 1'b1, rise_c + TO + 3});
      measuring = 0;
   endtask

   initial begin
      int c;
      int p;
      int h;

      tick(3);
      @(negedge clk);
      check("rst_sample", int'(sample), 0);
      check("rst_valid", int'(sample_valid), 0);
      check("rst_timeout", int'(timeout), 0);
      check("rst_overrun", int'(overrun), 0);
      tick(1);
      reset  = 1'b0;
      enable = 1'b1;
      tick(5);

      repeat (5) run_period(25, 100);
      finish_seq();
      repeat (3) run_period(100, 200);
      finish_seq();
      repeat (3) run_period(63, 64);
      finish_seq();

      repeat (8) run_period(5, 10);
      finish_seq();
      check("overrun_count_short", ovr_seen, exp_ovr);

      pin_rise();
      expect_to(SAMPLE_MAX);
      tick(TO + 40);
      pin_fall();
      tick(10);

      pin_rise();
      tick(4);
      pin_fall();
      expect_to(SAMPLE_MIN);
      tick(TO + 40);

      pin_rise();
      tick(10);
      enable    = 1'b0;
      measuring = 0;
      tick(19);
      pin_fall();
      tick(20);
      enable = 1'b1;
      tick(49);
      run_period(30, 100);
      run_period(30, 100);
      finish_seq();

      run_period(25, 100);
      pin_rise();
      c = cyc;
      tick(2);
      pwm_in = 1'b0;
      tick(c + 10 - cyc);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      held  = '0;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      measuring = 0;
      last_acc  = -1000;
      @(negedge clk);
      check("mid_rst_sample", int'(sample), 0);
      check("mid_rst_valid", int'(sample_valid), 0);
      check("mid_rst_timeout", int'(timeout), 0);
      check("mid_rst_overrun", int'(overrun), 0);
      tick(40);

      repeat (40) begin
         p = $urandom_range(250, 2);
         h = $urandom_range(p - 1, 1);
         run_period(h, p);
      end
      finish_seq();

      tick(50);
      check("queue_drained", q.size(), 0);
      check("overrun_count_total", ovr_seen, exp_ovr);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
